dmem_stall: RTL and testbench

Parametrised multi-cycle data memory for the pipelined MIPS core, replacing the single-cycle data memory on the M-stage bus. It accepts one load/store per request, models a configurable access latency, and drives a `stall` output that the hazard unit ORs into its stall/flush logic. Word depth, data width and latency are parameters.

---
 rtl/dmem_stall_if.sv | 33 +++
 rtl/dmem_stall.sv | 125 ++++++++++++
 tb/tb_dmem_stall.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_stall_if.sv
// M-stage data-memory bus between the pipelined core (master) and dmem_stall (slave).
// The be lane-enable signal exists only when DMEM_BYTE_EN is defined.
interface dmem_stall_if #(
  parameter int WIDTH = 32
);
  logic             memreq;
  logic             memwrite;
  logic [31:0]      addr;
  logic [WIDTH-1:0] writedata;
`ifdef DMEM_BYTE_EN
  logic [WIDTH/8-1:0] be;
`endif
  logic [WIDTH-1:0] readdata;
  logic             stall;
  logic             done;
  logic             error;

  modport master (
    output memreq, memwrite, addr, writedata,
`ifdef DMEM_BYTE_EN
    output be,
`endif
    input  readdata, stall, done, error
  );

  modport slave (
    input  memreq, memwrite, addr, writedata,
`ifdef DMEM_BYTE_EN
    input  be,
`endif
    output readdata, stall, done, error
  );
endinterface

// File: rtl/dmem_stall.sv
// Multi-cycle data memory for the pipelined MIPS core; stalls the pipeline for LATENCY cycles per access.
// Optional feature macro: DMEM_BYTE_EN (per-lane store enables, sb/sh stores skip the alignment check).
module dmem_stall #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_stall_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [3:0]       cnt, cnt_next;

  logic [AW+1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             req_write;
`ifdef DMEM_BYTE_EN
  logic [NB-1:0]    req_be;
`endif

  logic [AW+1:0]    cur_addr;
  logic [WIDTH-1:0] cur_wdata;
  logic             cur_write;
  logic [NB-1:0]    cur_be;
  logic [AW-1:0]    cur_idx;
  logic             cur_misaligned;
  logic             accept, finish, do_write;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] readdata_r;
  logic             unused_addr_hi;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

  // Addresses alias modulo DEPTH*4, so the upper address bits are deliberately dropped.
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign accept = (state == IDLE) && bus.memreq;

  // With LATENCY=1 the DONE edge coincides with acceptance, so the live inputs stand in for the latch.
  assign cur_addr  = (state == IDLE) ? bus.addr[AW+1:0] : req_addr;
  assign cur_wdata = (state == IDLE) ? bus.writedata    : req_wdata;
  assign cur_write = (state == IDLE) ? bus.memwrite     : req_write;
`ifdef DMEM_BYTE_EN
  assign cur_be         = (state == IDLE) ? bus.be : req_be;
  assign cur_misaligned = misaligned(cur_addr[1:0]) && !cur_write;
`else
  assign cur_be         = '1;
  assign cur_misaligned = misaligned(cur_addr[1:0]);
`endif
  assign cur_idx  = cur_addr[AW+1:2];
  assign finish   = (state_next == DONE);
  assign do_write = finish && cur_write && !cur_misaligned && !reset;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.memreq) begin
          if (LATENCY == 1) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      readdata_r <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (finish) begin
        if (cur_misaligned)  readdata_r <= '0;
        else if (!cur_write) readdata_r <= mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr  <= bus.addr[AW+1:0];
      req_wdata <= bus.writedata;
      req_write <= bus.memwrite;
`ifdef DMEM_BYTE_EN
      req_be    <= bus.be;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign bus.stall    = ((state == IDLE) && bus.memreq) || (state == BUSY);
  assign bus.done     = (state == DONE);
  assign bus.error    = (state == DONE) && cur_misaligned;
  assign bus.readdata = readdata_r;
endmodule

// File: tb/tb_dmem_stall.sv
// Directed bench for dmem_stall: three instances at LATENCY 2, 1 and 4 share one clock.
// Instance 0 = LATENCY 2, instance 1 = LATENCY 1, instance 2 = LATENCY 4.
module tb_dmem_stall;
  logic        clk = 1'b0;
  logic        rst      [3];
  logic        memreq   [3];
  logic        memwrite [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
`ifdef DMEM_BYTE_EN
  logic [3:0]  be       [3];
`endif
  logic [31:0] readdata [3];
  logic        stall    [3];
  logic        done     [3];
  logic        error    [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_stall_if #(.WIDTH(32)) bus ();
    dmem_stall #(
      .WIDTH  (32),
      .DEPTH  (64),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus)
    );
    assign bus.memreq    = memreq[g];
    assign bus.memwrite  = memwrite[g];
    assign bus.addr      = addr[g];
    assign bus.writedata = wdata[g];
`ifdef DMEM_BYTE_EN
    assign bus.be        = be[g];
`endif
    assign readdata[g] = bus.readdata;
    assign stall[g]    = bus.stall;
    assign done[g]     = bus.done;
    assign error[g]    = bus.error;
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after a rising edge with the instance idle.
  task automatic access(input int s, input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
    memreq[s]   = 1'b1;
    memwrite[s] = wr;
    addr[s]     = a;
    wdata[s]    = wd;
    for (int c = 0; c < lat_of(s); c++) begin
      @(negedge clk);
      chk($sformatf("%s stall c%0d", tag, c), stall[s], 1'b1);
      chk($sformatf("%s done c%0d", tag, c), done[s], 1'b0);
      @(posedge clk); #1;
      // The request is latched; scrambled inputs must not matter from here on.
      addr[s]  = ~a;
      wdata[s] = ~wd;
      memwrite[s] = ~wr;
    end
    @(negedge clk);
    chk($sformatf("%s stall at done", tag), stall[s], 1'b0);
    chk($sformatf("%s done pulse", tag), done[s], 1'b1);
    rd  = readdata[s];
    err = error[s];
    @(posedge clk); #1;
    memreq[s] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s idle stall", tag), stall[s], 1'b0);
    chk($sformatf("%s idle done", tag), done[s], 1'b0);
    chk($sformatf("%s idle error", tag), error[s], 1'b0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        err;
  logic [31:0] b2b_addr [3] = '{32'h20, 32'h24, 32'h28};
  logic [31:0] b2b_val  [3] = '{32'h0000100A, 32'h0000200B, 32'h0000300C};

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1; memreq[s] = 1'b0; memwrite[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
`ifdef DMEM_BYTE_EN
      be[s] = 4'hF;
`endif
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d readdata", s), readdata[s], 32'h0);
      chk($sformatf("reset%0d stall", s), stall[s], 1'b0);
      chk($sformatf("reset%0d done", s), done[s], 1'b0);
      chk($sformatf("reset%0d error", s), error[s], 1'b0);
      rst[s] = 1'b0;
    end
    @(posedge clk); #1;

    // Store then load, LATENCY=2
    access(0, "st40", 1'b1, 32'h40, 32'hDEADBEEF, rd, err);
    chk("st40 error", err, 1'b0);
    access(0, "ld40", 1'b0, 32'h40, 32'h0, rd, err);
    chk("ld40 readdata", rd, 32'hDEADBEEF);
    chk("ld40 error", err, 1'b0);

    // Misaligned load clears readdata and flags error
    access(0, "ld42", 1'b0, 32'h42, 32'h0, rd, err);
    chk("ld42 readdata", rd, 32'h0);
    chk("ld42 error", err, 1'b1);
`ifndef DMEM_BYTE_EN
    access(0, "st42", 1'b1, 32'h42, 32'h55555555, rd, err);
    chk("st42 error", err, 1'b1);
    access(0, "ld40b", 1'b0, 32'h40, 32'h0, rd, err);
    chk("ld40b unchanged", rd, 32'hDEADBEEF);
    chk("ld40b error", err, 1'b0);
`endif

    // Aliasing modulo DEPTH*4 = 0x100
    access(0, "st100", 1'b1, 32'h100, 32'h11111111, rd, err);
    access(0, "ld000", 1'b0, 32'h000, 32'h0, rd, err);
    chk("alias readdata", rd, 32'h11111111);

`ifdef DMEM_BYTE_EN
    be[0] = 4'hF;
    access(0, "st08", 1'b1, 32'h08, 32'hAABBCCDD, rd, err);
    be[0] = 4'b0001;
    access(0, "sb08", 1'b1, 32'h08, 32'h00000011, rd, err);
    chk("sb08 error", err, 1'b0);
    be[0] = 4'hF;
    access(0, "ld08", 1'b0, 32'h08, 32'h0, rd, err);
    chk("ld08 merged", rd, 32'hAABBCC11);
    chk("ld08 error", err, 1'b0);
`endif

    // LATENCY=1 back-to-back loads with memreq held high
    for (int k = 0; k < 3; k++)
      access(1, $sformatf("pre%0d", k), 1'b1, b2b_addr[k], b2b_val[k], rd, err);
    memreq[1] = 1'b1;
    memwrite[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr[1] = b2b_addr[k];
      @(negedge clk);
      chk($sformatf("b2b%0d stall", k), stall[1], 1'b1);
      chk($sformatf("b2b%0d no done", k), done[1], 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("b2b%0d no stall", k), stall[1], 1'b0);
      chk($sformatf("b2b%0d done", k), done[1], 1'b1);
      chk($sformatf("b2b%0d readdata", k), readdata[1], b2b_val[k]);
      @(posedge clk); #1;
    end
    memreq[1] = 1'b0;
    @(negedge clk);
    chk("b2b tail stall", stall[1], 1'b0);
    chk("b2b tail done", done[1], 1'b0);
    @(posedge clk); #1;

    // Reset mid-access, LATENCY=4
    access(2, "st10", 1'b1, 32'h10, 32'hA5A5A5A5, rd, err);
    access(2, "ld10", 1'b0, 32'h10, 32'h0, rd, err);
    chk("ld10 readdata", rd, 32'hA5A5A5A5);
    memreq[2] = 1'b1; memwrite[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'h12345678;
    repeat (2) begin @(posedge clk); #1; end
    memreq[2] = 1'b0;
    rst[2] = 1'b1;
    #1;
    chk("rstmid readdata", readdata[2], 32'h0);
    chk("rstmid stall", stall[2], 1'b0);
    chk("rstmid done", done[2], 1'b0);
    chk("rstmid error", error[2], 1'b0);
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    @(posedge clk); #1;
    access(2, "ld10r", 1'b0, 32'h10, 32'h0, rd, err);
    chk("ld10r prior contents", rd, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
